conv2d_engine: RTL and testbench

Parametrised successor to the convolution controller. Sweeps every channel, row and column of an interleaved image in memory and applies a K×K signed kernel at each pixel, with border padding. Fetches pixels and coefficients over two 1-cycle-latency read ports and runs an internal multiply-accumulate. Streams one ACC_W result per output pixel over a valid/ready handshake. Sits between the image/kernel memories and the downstream result writer.

---
 rtl/conv2d_engine.sv | 279 +++++++++++++++++++++++++++
 tb/tb_conv2d_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_engine.sv
// conv2d_engine: KxK signed convolution over an interleaved multi-channel image, one result per pixel.
// Define CONV_REPLICATE_PAD_EN to replicate edge pixels into the border instead of zero padding.
module conv2d_engine #(
    parameter int PIX_W    = 8,
    parameter int COEF_W   = 8,
    parameter int ACC_W    = 32,
    parameter int CHANNELS = 3,
    parameter int MAX_K    = 7,
    parameter int DIM_W    = 12,
    parameter int ADDR_W   = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] ImageBase,
    input  logic [ADDR_W-1:0] RowStride,
    input  logic [ADDR_W-1:0] KernelBase,
    input  logic [DIM_W-1:0]  ImgCols,
    input  logic [DIM_W-1:0]  ImgRows,
    input  logic [3:0]        KernelSize,
    output logic              PixRdEn,
    output logic [ADDR_W-1:0] PixAddr,
    input  logic [PIX_W-1:0]  PixRdData,
    output logic              CoefRdEn,
    output logic [ADDR_W-1:0] CoefAddr,
    input  logic [COEF_W-1:0] CoefRdData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [ACC_W-1:0]  OutData,
    output logic [1:0]        OutChan,
    output logic [DIM_W-1:0]  OutRow,
    output logic [DIM_W-1:0]  OutCol,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    localparam int SW = DIM_W + 1;
    localparam int PW = COEF_W + PIX_W + 1;
    localparam logic [1:0] LAST_CHAN = 2'(CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state;

    logic [ADDR_W-1:0] img_base, row_stride, kern_base;
    logic [DIM_W-1:0]  img_cols, img_rows;
    logic [3:0]        k_size;
    logic [1:0]        chan;
    logic [DIM_W-1:0]  row, col;
    logic [3:0]        kr, kc;
    logic [ACC_W-1:0]  acc;
    logic              pend_vld, pend_pix;

    logic [1:0]        nxt_chan;
    logic [DIM_W-1:0]  nxt_row, nxt_col;
    logic              last_tap, last_out, k_ok;

    logic [ADDR_W-1:0] t_base, t_stride, t_kbase;
    logic [DIM_W-1:0]  t_cols, t_rows, t_row, t_col;
    logic [3:0]        t_k, t_kr, t_kc, t_c;
    logic [1:0]        t_chan;
    logic signed [SW-1:0] ty, tx;
    logic [ADDR_W-1:0] ya, xa;
    logic              t_pix_en;
    logic [ADDR_W-1:0] t_pix_addr, t_coef_addr;
`ifdef CONV_REPLICATE_PAD_EN
    logic [DIM_W-1:0]  cy, cx;
`endif

    logic signed [PW-1:0] prod;
    logic [ACC_W-1:0]     prod_ext;

    assign k_ok = KernelSize[0] && (KernelSize <= 4'(MAX_K));

    // Position of the output that follows the current one, and end-of-loop flags.
    always_comb begin
        last_tap = (kr == k_size - 4'd1) && (kc == k_size - 4'd1);
        last_out = (chan == LAST_CHAN) && (row == img_rows - DIM_W'(1)) && (col == img_cols - DIM_W'(1));
        nxt_chan = chan;
        nxt_row  = row;
        nxt_col  = col + DIM_W'(1);
        if (col == img_cols - DIM_W'(1)) begin
            nxt_col = '0;
            nxt_row = row + DIM_W'(1);
            if (row == img_rows - DIM_W'(1)) begin
                nxt_row  = '0;
                nxt_chan = chan + 2'd1;
            end
        end
    end

    // Selects the tap to be issued at the coming edge; on Start the raw inputs are used
    // because the configuration registers are only being loaded at that edge.
    always_comb begin
        t_base   = img_base;
        t_stride = row_stride;
        t_kbase  = kern_base;
        t_cols   = img_cols;
        t_rows   = img_rows;
        t_k      = k_size;
        t_chan   = chan;
        t_row    = row;
        t_col    = col;
        t_kr     = 4'd0;
        t_kc     = 4'd0;
        case (state)
            S_IDLE: begin
                t_base   = ImageBase;
                t_stride = RowStride;
                t_kbase  = KernelBase;
                t_cols   = ImgCols;
                t_rows   = ImgRows;
                t_k      = KernelSize;
                t_chan   = 2'd0;
                t_row    = '0;
                t_col    = '0;
            end
            S_ISSUE: begin
                t_kr = kr;
                t_kc = kc + 4'd1;
                if (kc == k_size - 4'd1) begin
                    t_kr = kr + 4'd1;
                    t_kc = 4'd0;
                end
            end
            S_EMIT: begin
                t_chan = nxt_chan;
                t_row  = nxt_row;
                t_col  = nxt_col;
            end
            default: ;
        endcase
    end

    always_comb begin
        t_c = (t_k - 4'd1) >> 1;
        ty  = SW'(t_row) + SW'(t_kr) - SW'(t_c);
        tx  = SW'(t_col) + SW'(t_kc) - SW'(t_c);
`ifdef CONV_REPLICATE_PAD_EN
        cy = ty[SW-1] ? '0 : (ty[DIM_W-1:0] >= t_rows) ? t_rows - DIM_W'(1) : ty[DIM_W-1:0];
        cx = tx[SW-1] ? '0 : (tx[DIM_W-1:0] >= t_cols) ? t_cols - DIM_W'(1) : tx[DIM_W-1:0];
        ya = ADDR_W'(cy);
        xa = ADDR_W'(cx);
        t_pix_en = 1'b1;
`else
        ya = {{(ADDR_W-SW){ty[SW-1]}}, ty};
        xa = {{(ADDR_W-SW){tx[SW-1]}}, tx};
        t_pix_en = !(ty[SW-1] || (ty[DIM_W-1:0] >= t_rows) ||
                     tx[SW-1] || (tx[DIM_W-1:0] >= t_cols));
`endif
        t_pix_addr  = t_base + ya * t_stride + xa * ADDR_W'(CHANNELS) + ADDR_W'(t_chan);
        t_coef_addr = t_kbase + ADDR_W'(t_kr) * ADDR_W'(t_k) + ADDR_W'(t_kc);
    end

    // Pixel is unsigned, so it gets a zero sign bit before the signed multiply.
    assign prod     = PW'($signed(CoefRdData)) * PW'($signed({1'b0, PixRdData}));
    assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            img_base   <= '0;
            row_stride <= '0;
            kern_base  <= '0;
            img_cols   <= '0;
            img_rows   <= '0;
            k_size     <= '0;
            chan       <= '0;
            row        <= '0;
            col        <= '0;
            kr         <= '0;
            kc         <= '0;
            acc        <= '0;
            pend_vld   <= 1'b0;
            pend_pix   <= 1'b0;
            PixRdEn    <= 1'b0;
            PixAddr    <= '0;
            CoefRdEn   <= 1'b0;
            CoefAddr   <= '0;
            OutValid   <= 1'b0;
            OutData    <= '0;
            OutChan    <= '0;
            OutRow     <= '0;
            OutCol     <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Error      <= 1'b0;
        end else begin
            Done     <= 1'b0;
            Error    <= 1'b0;
            pend_vld <= CoefRdEn;
            pend_pix <= PixRdEn;
            if (pend_vld && pend_pix) begin
                acc <= acc + prod_ext;
            end
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (k_ok) begin
                            img_base   <= ImageBase;
                            row_stride <= RowStride;
                            kern_base  <= KernelBase;
                            img_cols   <= ImgCols;
                            img_rows   <= ImgRows;
                            k_size     <= KernelSize;
                            chan       <= '0;
                            row        <= '0;
                            col        <= '0;
                            kr         <= '0;
                            kc         <= '0;
                            acc        <= '0;
                            Busy       <= 1'b1;
                            PixRdEn    <= t_pix_en;
                            PixAddr    <= t_pix_addr;
                            CoefRdEn   <= 1'b1;
                            CoefAddr   <= t_coef_addr;
                            state      <= S_ISSUE;
                        end else begin
                            Error <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (last_tap) begin
                        PixRdEn  <= 1'b0;
                        CoefRdEn <= 1'b0;
                        state    <= S_DRAIN;
                    end else begin
                        kr       <= t_kr;
                        kc       <= t_kc;
                        PixRdEn  <= t_pix_en;
                        PixAddr  <= t_pix_addr;
                        CoefRdEn <= 1'b1;
                        CoefAddr <= t_coef_addr;
                    end
                end
                S_DRAIN: state <= S_EMIT;
                S_EMIT: begin
                    if (!OutValid) begin
                        OutValid <= 1'b1;
                        OutData  <= acc;
                        OutChan  <= chan;
                        OutRow   <= row;
                        OutCol   <= col;
                    end else if (OutReady) begin
                        OutValid <= 1'b0;
                        if (last_out) begin
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            chan     <= nxt_chan;
                            row      <= nxt_row;
                            col      <= nxt_col;
                            kr       <= '0;
                            kc       <= '0;
                            acc      <= '0;
                            PixRdEn  <= t_pix_en;
                            PixAddr  <= t_pix_addr;
                            CoefRdEn <= 1'b1;
                            CoefAddr <= t_coef_addr;
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_engine.sv
// tb_conv2d_engine: frames of the convolution engine compared with a nested-loop convolution model.
module tb_conv2d_engine;

    localparam int PIX_W = 8, COEF_W = 8, ACC_W = 32, CHANNELS = 3, MAX_K = 7, DIM_W = 12, ADDR_W = 32;
    localparam int IMG_BASE = 64, KERN_BASE = 8;

    logic              Clk = 1'b0, Reset = 1'b1, Start = 1'b0;
    logic [ADDR_W-1:0] ImageBase = '0, RowStride = '0, KernelBase = '0;
    logic [DIM_W-1:0]  ImgCols = '0, ImgRows = '0;
    logic [3:0]        KernelSize = '0;
    logic              PixRdEn, CoefRdEn, OutValid, Busy, Done, Error;
    logic [ADDR_W-1:0] PixAddr, CoefAddr;
    logic [PIX_W-1:0]  PixRdData = '0;
    logic [COEF_W-1:0] CoefRdData = '0;
    logic              OutReady = 1'b0;
    logic [ACC_W-1:0]  OutData;
    logic [1:0]        OutChan;
    logic [DIM_W-1:0]  OutRow, OutCol;

    conv2d_engine #(.PIX_W(PIX_W), .COEF_W(COEF_W), .ACC_W(ACC_W), .CHANNELS(CHANNELS),
                    .MAX_K(MAX_K), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .ImageBase(ImageBase), .RowStride(RowStride), .KernelBase(KernelBase),
        .ImgCols(ImgCols), .ImgRows(ImgRows), .KernelSize(KernelSize),
        .PixRdEn(PixRdEn), .PixAddr(PixAddr), .PixRdData(PixRdData),
        .CoefRdEn(CoefRdEn), .CoefAddr(CoefAddr), .CoefRdData(CoefRdData),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
        .OutChan(OutChan), .OutRow(OutRow), .OutCol(OutCol),
        .Busy(Busy), .Done(Done), .Error(Error)
    );

    initial forever #5 Clk = ~Clk;

    typedef struct packed {
        logic [1:0]  ch;
        logic [11:0] r;
        logic [11:0] c;
        logic [31:0] d;
    } res_t;

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Memories answer one cycle after the strobe; idle cycles return junk.
    logic [7:0] pix_mem  [0:4095];
    logic [7:0] coef_mem [0:63];
    always @(posedge Clk) begin
        PixRdData  <= PixRdEn  ? pix_mem[PixAddr[11:0]]  : 8'($urandom);
        CoefRdData <= CoefRdEn ? coef_mem[CoefAddr[5:0]] : 8'($urandom);
    end

    res_t exp_q[$];
    res_t got_q[$];
    int   got_cyc[$];
    int   exp_pix_rd, cur_stride;

    task automatic build_model(input int cols, input int rows, input int k);
        int cc, y, x;
        longint sum;
        res_t e;
        exp_q.delete();
        exp_pix_rd = 0;
        cc = (k - 1) / 2;
        for (int ch = 0; ch < CHANNELS; ch++)
            for (int r = 0; r < rows; r++)
                for (int c = 0; c < cols; c++) begin
                    sum = 0;
                    for (int i = 0; i < k; i++)
                        for (int j = 0; j < k; j++) begin
                            y = r + i - cc;
                            x = c + j - cc;
`ifdef CONV_REPLICATE_PAD_EN
                            y = (y < 0) ? 0 : (y >= rows) ? rows - 1 : y;
                            x = (x < 0) ? 0 : (x >= cols) ? cols - 1 : x;
`endif
                            if (y >= 0 && y < rows && x >= 0 && x < cols) begin
                                sum += longint'($signed(coef_mem[KERN_BASE + i * k + j])) *
                                       longint'(pix_mem[IMG_BASE + y * cur_stride + x * CHANNELS + ch]);
                                exp_pix_rd++;
                            end
                        end
                    e.ch = 2'(ch);
                    e.r  = 12'(r);
                    e.c  = 12'(c);
                    e.d  = 32'(sum);
                    exp_q.push_back(e);
                end
    endtask

    int cyc = 0, pix_rd = 0, coef_rd = 0, done_cnt = 0, err_cnt = 0, stall_cnt = 0, first_vld = -1;
    logic        prev_stall = 1'b0;
    logic [63:0] snap = '0;

    always @(negedge Clk) begin
        res_t r;
        cyc++;
        if (PixRdEn)  pix_rd++;
        if (CoefRdEn) coef_rd++;
        if (Error)    err_cnt++;
        if (Done) begin
            done_cnt++;
            check("busy_at_done", 64'(Busy), 64'd0);
            if (got_cyc.size() > 0) check("done_lag", 64'(cyc - got_cyc[$]), 64'd1);
        end
        if (prev_stall)
            check("stall_hold", 64'({OutValid, OutChan, OutRow, OutCol, OutData}), snap);
        if (OutValid && !OutReady && !Reset) begin
            stall_cnt++;
            check("stall_no_rd", 64'({PixRdEn, CoefRdEn}), 64'd0);
        end
        if (OutValid && first_vld < 0) first_vld = cyc;
        if (OutValid && OutReady) begin
            r.ch = OutChan; r.r = OutRow; r.c = OutCol; r.d = OutData;
            got_q.push_back(r);
            got_cyc.push_back(cyc);
        end
        prev_stall = OutValid && !OutReady && !Reset;
        snap = 64'({OutValid, OutChan, OutRow, OutCol, OutData});
    end

    // 0: always ready, 1: random ready, 2: hold low for the first 5 valid cycles then ready.
    int ready_mode = 0, hold_cnt = 0;
    initial forever begin
        @(posedge Clk); #1;
        case (ready_mode)
            0: OutReady = 1'b1;
            1: OutReady = ($urandom_range(0, 3) != 0);
            default: begin
                if (OutValid && hold_cnt < 5) begin OutReady = 1'b0; hold_cnt++; end
                else if (OutValid) begin OutReady = 1'b1; ready_mode = 0; end
                else OutReady = 1'b0;
            end
        endcase
    end

    task automatic fill(input bit rnd, input logic [7:0] pv, input logic [7:0] cv);
        for (int i = 0; i < 4096; i++) pix_mem[i] = rnd ? 8'($urandom) : pv;
        for (int i = 0; i < 64; i++)   coef_mem[i] = rnd ? 8'($urandom) : cv;
    endtask

    task automatic set_cfg(input int cols, input int rows, input int k);
        cur_stride = cols * CHANNELS + 5;
        ImageBase  = ADDR_W'(IMG_BASE);
        RowStride  = ADDR_W'(cur_stride);
        KernelBase = ADDR_W'(KERN_BASE);
        ImgCols    = DIM_W'(cols);
        ImgRows    = DIM_W'(rows);
        KernelSize = 4'(k);
    endtask

    task automatic run_frame(input int cols, input int rows, input int k, input int mode,
                             input bit poke, input string nm);
        int p0, c0, d0, e0, s0, start_cyc;
        bit seen_done;
        set_cfg(cols, rows, k);
        build_model(cols, rows, k);
        got_q.delete(); got_cyc.delete();
        first_vld = -1; hold_cnt = 0; ready_mode = mode;
        p0 = pix_rd; c0 = coef_rd; d0 = done_cnt; e0 = err_cnt; s0 = stall_cnt;
        @(posedge Clk); #1; Start = 1'b1;
        @(negedge Clk); #1; start_cyc = cyc;
        @(posedge Clk); #1; Start = 1'b0;
        check({nm, "_busy_rd1"}, 64'({Busy, CoefRdEn}), 64'b11);
        seen_done = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            @(posedge Clk); #1;
            if (Done) begin seen_done = 1'b1; break; end
            if (poke) begin
                Start = (i % 9 == 4);
                KernelSize = 4'd4;
                ImgCols = DIM_W'(7);
            end
        end
        Start = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check({nm, "_done_seen"}, 64'(seen_done), 64'd1);
        check({nm, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
        check({nm, "_err_cnt"}, 64'(err_cnt - e0), 64'd0);
        check({nm, "_n_out"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_out%0d", nm, i), 64'(got_q[i]), 64'(exp_q[i]));
        check({nm, "_pix_rd"}, 64'(pix_rd - p0), 64'(exp_pix_rd));
        check({nm, "_coef_rd"}, 64'(coef_rd - c0), 64'(exp_q.size() * k * k));
        check({nm, "_first_vld"}, 64'(first_vld - start_cyc), 64'(k * k + 3));
        if (mode == 0)
            for (int i = 1; i < got_cyc.size(); i++)
                check($sformatf("%s_space%0d", nm, i), 64'(got_cyc[i] - got_cyc[i-1]), 64'(k * k + 3));
        if (mode == 2) check({nm, "_stall_cycles"}, 64'(stall_cnt - s0), 64'd5);
    endtask

    task automatic illegal(input int k);
        int e0, p0, c0;
        e0 = err_cnt; p0 = pix_rd; c0 = coef_rd;
        set_cfg(3, 3, k);
        @(posedge Clk); #1; Start = 1'b1;
        @(posedge Clk); #1; Start = 1'b0;
        check($sformatf("ill%0d_err_on", k), 64'({Error, Busy}), 64'b10);
        @(posedge Clk); #1;
        check($sformatf("ill%0d_err_off", k), 64'({Error, Busy}), 64'b00);
        repeat (3) @(posedge Clk);
        #1;
        check($sformatf("ill%0d_err_cnt", k), 64'(err_cnt - e0), 64'd1);
        check($sformatf("ill%0d_reads", k), 64'((pix_rd - p0) + (coef_rd - c0)), 64'd0);
    endtask

    initial begin
        int d0;
        bit got5;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_ctl", 64'({OutValid, Busy, Done, Error, PixRdEn, CoefRdEn}), 64'd0);
        check("rst_dat", 64'({OutData, OutChan, OutRow, OutCol}), 64'd0);
        Reset = 1'b0;

        fill(1'b0, 8'd10, 8'd1);
        run_frame(4, 4, 3, 0, 1'b0, "pad");
        if (got_q.size() >= 6) begin
`ifdef CONV_REPLICATE_PAD_EN
            check("pad_corner", 64'(got_q[0].d), 64'd90);
            check("pad_edge", 64'(got_q[1].d), 64'd90);
`else
            check("pad_corner", 64'(got_q[0].d), 64'd40);
            check("pad_edge", 64'(got_q[1].d), 64'd60);
`endif
            check("pad_inner", 64'(got_q[5].d), 64'd90);
        end

        fill(1'b0, 8'd200, 8'hFE);
        run_frame(3, 1, 1, 0, 1'b0, "sgn");
        if (got_q.size() > 0) check("sgn_val", 64'(got_q[0].d), 64'hFFFF_FE70);

        fill(1'b1, 8'd0, 8'd0);
        run_frame(3, 3, 3, 2, 1'b0, "bp");

        illegal(4);
        illegal(9);

        for (int t = 0; t < 4; t++) begin
            fill(1'b1, 8'd0, 8'd0);
            run_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                      2 * int'($urandom_range(0, 3)) + 1, 1, 1'b0, $sformatf("rnd%0d", t));
        end

        // Reset in the middle of a frame, right after the fifth result is taken.
        fill(1'b1, 8'd0, 8'd0);
        set_cfg(3, 3, 3);
        build_model(3, 3, 3);
        got_q.delete(); got_cyc.delete(); ready_mode = 0;
        d0 = done_cnt;
        @(posedge Clk); #1; Start = 1'b1;
        @(posedge Clk); #1; Start = 1'b0;
        got5 = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge Clk);
            if (got_q.size() >= 5) begin got5 = 1'b1; break; end
        end
        check("mid_reached5", 64'(got5), 64'd1);
        @(posedge Clk); #1; Reset = 1'b1;
        @(posedge Clk); #1;
        check("mid_rst_ctl", 64'({OutValid, Busy, Done, Error, PixRdEn, CoefRdEn}), 64'd0);
        check("mid_rst_dat", 64'({OutData, OutChan, OutRow, OutCol}), 64'd0);
        check("mid_rst_addr", {PixAddr, CoefAddr}, 64'd0);
        Reset = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        check("mid_no_done", 64'(done_cnt - d0), 64'd0);
        check("mid_n_out", 64'(got_q.size()), 64'd5);
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            check($sformatf("mid_out%0d", i), 64'(got_q[i]), 64'(exp_q[i]));

        fill(1'b1, 8'd0, 8'd0);
        run_frame(3, 2, 3, 0, 1'b1, "fresh");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
